// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one byte per transaction, MSB first, SCLK from a clk divider.
// Sends the sample strobe to an external spi_rx shift stage and captures its byte when done.
module spi_master_ctrl #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned DIV_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_sclk,
    output logic       o_cs_n,
    output logic       o_mosi,
    output logic       o_clk_spi_sample,
    input  logic [7:0] i_rx_byte,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid
);

    typedef enum logic [2:0] {StIdle, StLead, StHigh, StLow, StTrail} state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               sclk_q, sclk_d;
    logic               cs_n_q, cs_n_d;
    logic               mosi_q, mosi_d;
    logic               sample_q, sample_d;
    logic [7:0]         rx_byte_q, rx_byte_d;
    logic               rx_valid_q, rx_valid_d;
    logic               div_end;

    assign div_end = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        sample_d   = 1'b0;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_tx_valid) begin
                    shift_d = i_tx_byte;
                    mosi_d  = i_tx_byte[7];
                    cs_n_d  = 1'b0;
                    bit_d   = 3'd0;
                    div_d   = '0;
                    state_d = StLead;
                end
            end
            StLead, StLow: begin
                if (div_end) begin
                    sclk_d   = 1'b1;
                    sample_d = 1'b1;
                    div_d    = '0;
                    state_d  = StHigh;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StHigh: begin
                if (div_end) begin
                    sclk_d = 1'b0;
                    div_d  = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StTrail;
                    end else begin
                        // Rotate so the next bit to send always sits at [7]; [6] is the next one out.
                        bit_d   = bit_q + 3'd1;
                        shift_d = {shift_q[6:0], shift_q[7]};
                        mosi_d  = shift_q[6];
                        state_d = StLow;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StTrail: begin
                if (div_end) begin
                    cs_n_d     = 1'b1;
                    rx_byte_d  = i_rx_byte;
                    rx_valid_d = 1'b1;
                    div_d      = '0;
                    state_d    = StIdle;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            div_q      <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            sample_q   <= 1'b0;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            sample_q   <= sample_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign o_tx_ready       = (state_q == StIdle);
    assign o_sclk           = sclk_q;
    assign o_cs_n           = cs_n_q;
    assign o_mosi           = mosi_q;
    assign o_clk_spi_sample = sample_q;
    assign o_rx_byte        = rx_byte_q;
    assign o_rx_valid       = rx_valid_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: instance 0 at CLK_DIV=2, instance 1 at CLK_DIV=1,
// each looped back through a small spi_rx model (shift MOSI in on the sample strobe).
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst_n    [2];
    logic [7:0] tx_byte  [2];
    logic       tx_valid [2];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned Div = (g == 0) ? 2 : 1;

        logic       tx_ready, sclk, cs_n, mosi, samp, rx_valid;
        logic [7:0] rx_byte;
        logic [7:0] rx_shift = 8'h00;
        logic [7:0] mosi_log = 8'h00;
        logic [15:0] rx_hist = 16'h0000;
        logic       sclk_p = 1'b0, cs_p = 1'b1, mosi_p = 1'b0, rxv_p = 1'b0;
        int cyc = 0, cs_low = 0, strobes = 0, rxv = 0, sclk_hi = 0;
        int gap_err = 0, samp_err = 0, mosi_err = 0, ready_err = 0, pulse_err = 0;
        int hi_run = 0, last_hi_run = 0, last_strobe = -1;

        spi_master_ctrl #(.CLK_DIV(Div), .DIV_W(8)) u_dut (
            .clk              (clk),
            .reset            (rst_n[g]),
            .i_tx_byte        (tx_byte[g]),
            .i_tx_valid       (tx_valid[g]),
            .o_tx_ready       (tx_ready),
            .o_sclk           (sclk),
            .o_cs_n           (cs_n),
            .o_mosi           (mosi),
            .o_clk_spi_sample (samp),
            .i_rx_byte        (rx_shift),
            .o_rx_byte        (rx_byte),
            .o_rx_valid       (rx_valid)
        );

        always @(posedge clk) begin
            if (samp === 1'b1) rx_shift <= {rx_shift[6:0], mosi};
        end

        always @(negedge clk) begin
            cyc <= cyc + 1;
            if (cs_n === 1'b0) cs_low <= cs_low + 1;
            if (sclk === 1'b1) sclk_hi <= sclk_hi + 1;
            if (cs_n !== 1'b0) last_strobe <= -1;
            if (samp === 1'b1) begin
                strobes  <= strobes + 1;
                mosi_log <= {mosi_log[6:0], mosi};
                if (last_strobe >= 0 && cyc - last_strobe != 2 * Div) gap_err <= gap_err + 1;
                last_strobe <= cyc;
            end
            if (!$isunknown({samp, sclk, sclk_p}) && (samp != (sclk && !sclk_p)))
                samp_err <= samp_err + 1;
            // MOSI may only move on an SCLK fall or when CS_n toggles (accept / reset).
            if (!$isunknown({mosi, mosi_p, sclk, sclk_p, cs_n, cs_p}) && mosi != mosi_p
                && !(sclk_p && !sclk) && cs_p == cs_n)
                mosi_err <= mosi_err + 1;
            if (!$isunknown(cs_n) && tx_ready !== cs_n) ready_err <= ready_err + 1;
            if (cs_n === 1'b1) begin
                hi_run <= hi_run + 1;
            end else if (hi_run > 0) begin
                last_hi_run <= hi_run;
                hi_run      <= 0;
            end
            if (rx_valid === 1'b1) begin
                rxv     <= rxv + 1;
                rx_hist <= {rx_hist[7:0], rx_byte};
                if (rxv_p) pulse_err <= pulse_err + 1;
            end
            rxv_p  <= (rx_valid === 1'b1);
            sclk_p <= sclk;
            cs_p   <= cs_n;
            mosi_p <= mosi;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int s_cs, s_str, s_rxv, s_hi;

    initial begin
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        tx_valid[0] = 1'b0; tx_valid[1] = 1'b0;
        tx_byte[0] = 8'h00; tx_byte[1] = 8'h00;

        // 1. reset
        repeat (3) @(negedge clk);
        chk("rst_cs_n",  32'(g_dut[0].cs_n), 32'd1);
        chk("rst_sclk",  32'(g_dut[0].sclk), 32'd0);
        chk("rst_ready", 32'(g_dut[0].tx_ready), 32'd1);
        chk("rst_rxbyte", 32'(g_dut[0].rx_byte), 32'h00);
        chk("rst_samp",  32'(g_dut[0].samp), 32'd0);
        chk("rst_rxv",   32'(g_dut[0].rx_valid), 32'd0);
        chk("rst_mosi",  32'(g_dut[0].mosi), 32'd0);
        chk("rst1_cs_n", 32'(g_dut[1].cs_n), 32'd1);
        chk("rst1_sclk", 32'(g_dut[1].sclk), 32'd0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        repeat (2) @(negedge clk);

        // 2. CLK_DIV=2, send A5; byte changed after accept must not matter
        s_cs = g_dut[0].cs_low; s_str = g_dut[0].strobes; s_rxv = g_dut[0].rxv;
        s_hi = g_dut[0].sclk_hi;
        tx_byte[0] = 8'hA5; tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0; tx_byte[0] = 8'h00;
        chk("t2_ready_low", 32'(g_dut[0].tx_ready), 32'd0);
        chk("t2_cs_low",    32'(g_dut[0].cs_n), 32'd0);
        chk("t2_mosi_msb",  32'(g_dut[0].mosi), 32'd1);
        repeat (40) @(negedge clk);
        chk("t2_cs_cycles", 32'(g_dut[0].cs_low - s_cs), 32'd34);
        chk("t2_strobes",   32'(g_dut[0].strobes - s_str), 32'd8);
        chk("t2_mosi_seq",  32'(g_dut[0].mosi_log), 32'hA5);
        chk("t2_sclk_hi",   32'(g_dut[0].sclk_hi - s_hi), 32'd16);
        chk("t2_rxv",       32'(g_dut[0].rxv - s_rxv), 32'd1);
        chk("t2_rxbyte",    32'(g_dut[0].rx_byte), 32'hA5);
        chk("t2_ready_end", 32'(g_dut[0].tx_ready), 32'd1);

        // 3. back-to-back 3C then C3 with valid held
        s_cs = g_dut[0].cs_low; s_str = g_dut[0].strobes; s_rxv = g_dut[0].rxv;
        tx_byte[0] = 8'h3C; tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_byte[0] = 8'hC3;
        repeat (40) @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (40) @(negedge clk);
        chk("t3_cs_gap",    32'(g_dut[0].last_hi_run), 32'd1);
        chk("t3_rxv",       32'(g_dut[0].rxv - s_rxv), 32'd2);
        chk("t3_rx_hist",   32'(g_dut[0].rx_hist), 32'h3CC3);
        chk("t3_cs_cycles", 32'(g_dut[0].cs_low - s_cs), 32'd68);
        chk("t3_strobes",   32'(g_dut[0].strobes - s_str), 32'd16);

        // 4. FF request while busy with 00 is ignored
        s_cs = g_dut[0].cs_low; s_str = g_dut[0].strobes; s_rxv = g_dut[0].rxv;
        tx_byte[0] = 8'h00; tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (10) @(negedge clk);
        tx_byte[0] = 8'hFF; tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        chk("t4_ready_busy", 32'(g_dut[0].tx_ready), 32'd0);
        chk("t4_cs_busy",    32'(g_dut[0].cs_n), 32'd0);
        repeat (40) @(negedge clk);
        chk("t4_rxv",       32'(g_dut[0].rxv - s_rxv), 32'd1);
        chk("t4_rxbyte",    32'(g_dut[0].rx_byte), 32'h00);
        chk("t4_cs_cycles", 32'(g_dut[0].cs_low - s_cs), 32'd34);
        chk("t4_strobes",   32'(g_dut[0].strobes - s_str), 32'd8);
        chk("t4_mosi_seq",  32'(g_dut[0].mosi_log), 32'h00);

        // 5. reset at the 4th SCLK high, then a clean 5A
        s_str = g_dut[0].strobes; s_rxv = g_dut[0].rxv;
        tx_byte[0] = 8'hF0; tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (g_dut[0].strobes - s_str == 4) break;
            @(negedge clk);
        end
        chk("t5_reach4",  32'(g_dut[0].strobes - s_str), 32'd4);
        chk("t5_sclk_hi", 32'(g_dut[0].sclk), 32'd1);
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("t5_cs_n",   32'(g_dut[0].cs_n), 32'd1);
        chk("t5_sclk",   32'(g_dut[0].sclk), 32'd0);
        chk("t5_mosi",   32'(g_dut[0].mosi), 32'd0);
        chk("t5_ready",  32'(g_dut[0].tx_ready), 32'd1);
        chk("t5_rxbyte", 32'(g_dut[0].rx_byte), 32'h00);
        rst_n[0] = 1'b1;
        repeat (40) @(negedge clk);
        chk("t5_no_rxv", 32'(g_dut[0].rxv - s_rxv), 32'd0);
        tx_byte[0] = 8'h5A; tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (40) @(negedge clk);
        chk("t5_rxv_5a",  32'(g_dut[0].rxv - s_rxv), 32'd1);
        chk("t5_rx_5a",   32'(g_dut[0].rx_byte), 32'h5A);

        // 6. CLK_DIV=1, send 81
        s_cs = g_dut[1].cs_low; s_str = g_dut[1].strobes; s_rxv = g_dut[1].rxv;
        s_hi = g_dut[1].sclk_hi;
        tx_byte[1] = 8'h81; tx_valid[1] = 1'b1;
        @(negedge clk);
        tx_valid[1] = 1'b0;
        repeat (25) @(negedge clk);
        chk("t6_cs_cycles", 32'(g_dut[1].cs_low - s_cs), 32'd17);
        chk("t6_strobes",   32'(g_dut[1].strobes - s_str), 32'd8);
        chk("t6_sclk_hi",   32'(g_dut[1].sclk_hi - s_hi), 32'd8);
        chk("t6_mosi_seq",  32'(g_dut[1].mosi_log), 32'h81);
        chk("t6_rxv",       32'(g_dut[1].rxv - s_rxv), 32'd1);
        chk("t6_rxbyte",    32'(g_dut[1].rx_byte), 32'h81);

        // Invariants gathered by the monitors across the whole run
        chk("inv0_gap",   32'(g_dut[0].gap_err), 32'd0);
        chk("inv0_samp",  32'(g_dut[0].samp_err), 32'd0);
        chk("inv0_mosi",  32'(g_dut[0].mosi_err), 32'd0);
        chk("inv0_ready", 32'(g_dut[0].ready_err), 32'd0);
        chk("inv0_pulse", 32'(g_dut[0].pulse_err), 32'd0);
        chk("inv1_gap",   32'(g_dut[1].gap_err), 32'd0);
        chk("inv1_samp",  32'(g_dut[1].samp_err), 32'd0);
        chk("inv1_mosi",  32'(g_dut[1].mosi_err), 32'd0);
        chk("inv1_ready", 32'(g_dut[1].ready_err), 32'd0);
        chk("inv1_pulse", 32'(g_dut[1].pulse_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
